// File: rtl/ram_loader.sv
// Loads a byte stream into the program RAM, checks the trailing checksum byte,
// then reads the RAM back and compares the read-back sum with the written sum.
module ram_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic              ri,
    output logic              ro,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              xfer_err,
    output logic              verify_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        VERIFY,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        wsum;
    logic [7:0]        rsum;
    logic [7:0]        wsum_next;
    logic [7:0]        rsum_next;

    assign wsum_next = wsum + in_data;
    assign rsum_next = rsum + mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            wsum       <= '0;
            rsum       <= '0;
            xfer_err   <= 1'b0;
            verify_err <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        ptr        <= '0;
                        wsum       <= '0;
                        rsum       <= '0;
                        xfer_err   <= 1'b0;
                        verify_err <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        wsum <= wsum_next;
                        ptr  <= ptr + 1'b1;
                        if (ptr == LAST) begin
                            state <= CHECK;
                        end
                    end
                end
                // The checksum byte makes the stream sum to zero when intact.
                CHECK: begin
                    if (in_valid) begin
                        xfer_err <= (wsum_next != 8'h00);
                        state    <= VERIFY;
                    end
                end
                VERIFY: begin
                    rsum <= rsum_next;
                    ptr  <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        verify_err <= (rsum_next != wsum);
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM strobes are combinational so each byte lands on the accepting edge.
    always_comb begin
        in_ready    = (state == LOAD) || (state == CHECK);
        ri          = (state == LOAD) && in_valid;
        ro          = (state == VERIFY);
        mem_address = ptr;
        mem_wdata   = (state == LOAD) ? in_data : 8'h00;
        busy        = (state == LOAD) || (state == CHECK) || (state == VERIFY);
        done        = (state == DONE);
    end

endmodule
